fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Run-control FSM for the single-cycle core's program counter. It drives the PC's init/branch_en/branch_val inputs from decoded instruction flags, ALU condition and memory-busy status. It owns the start/done handshake with the test harness, implements stalls as zero-offset branches, and counts cycles and retired instructions. It sits between the decoder/ALU and the PC.

Parameters:
OFF_W, 8, width of the signed branch offset (matches PC branch_val)
CNT_W, 16, width of the cycle and instruction counters
MAX_CYCLES, 16'hFFFF, watchdog limit on run cycles before a forced stop

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  harness request to (re)start the program, level-sampled
is_branch  in  1  current instruction is a conditional branch
is_jump  in  1  current instruction is an unconditional jump
is_halt  in  1  current instruction is halt
cond_flag  in  1  ALU condition flag for conditional branches
offset  in  OFF_W  signed branch/jump offset of the current instruction
mem_busy  in  1  data memory is still completing the current access
pc_halt  in  1  halt flag from the PC (address space exhausted)
pc_init  out  1  synchronous init to the PC
branch_en  out  1  PC branch enable
branch_val  out  OFF_W  PC branch offset
done  out  1  program finished; registered
timeout  out  1  finish was caused by the watchdog; registered
cycle_count  out  CNT_W  cycles spent in RUN+STALL
instr_count  out  CNT_W  instructions retired

Behaviour:
- States: IDLE, INIT, RUN, STALL, DONE.
- Reset (RST_N=0, asynchronous): state IDLE, done=0, timeout=0, cycle_count=0, instr_count=0. Combinational outputs follow IDLE: pc_init=1, branch_en=0, branch_val=0. Reset mid-run aborts immediately and does not wait for a clock edge.
- pc_init, branch_en and branch_val are combinational from state and inputs. The PC samples them on the same edge.
- IDLE: pc_init=1. When start=1: counters are cleared, done=0, timeout=0, next state INIT.
- INIT: pc_init=1 for exactly one cycle, so PC=0 after this edge. Next state is RUN unconditionally.
- RUN: pc_init=0. The rules below are evaluated in priority order:
  1. is_halt: branch_en=1, branch_val=0 (PC frozen). The instruction retires. Next state DONE.
  2. pc_halt: branch_en=1, branch_val=0. No retire. Next state DONE.
  3. mem_busy: branch_en=1, branch_val=0. No retire. Next state STALL.
  4. is_jump, or is_branch with cond_flag=1: branch_en=1, branch_val=offset. The instruction retires.
  5. Otherwise: branch_en=0 (PC+1). The instruction retires.
- STALL: while mem_busy=1, branch_en=1, branch_val=0, no retire. When mem_busy=0, apply RUN rules 1, 2, 4 and 5 to the held instruction, retire it, and return to RUN (or go to DONE per rules 1 and 2).
- Watchdog: if cycle_count==MAX_CYCLES-1 while in RUN or STALL, the PC is frozen (branch_en=1, val=0), next state DONE, and timeout is set. The watchdog has priority over rules 1–5.
- DONE: done=1 (registered, so it asserts the cycle after entry). pc_init=0, branch_en=1, branch_val=0 to hold the PC. Counters are frozen. start=1 causes done=0, timeout=0, counters cleared, next state INIT.
- start is ignored in INIT, RUN and STALL.
- Counters:
  - cycle_count increments once per clock in RUN and STALL.
  - instr_count increments on every retiring cycle.
  - Both counters saturate at all-ones and never wrap.
- Offsets are passed through unmodified. Sign handling and wrap-around of PC+offset belong to the PC.
- The is_jump, is_branch and is_halt inputs are not assumed one-hot. Priority is halt > jump > branch.

Test Plan:
- RST_N low mid-RUN → state IDLE immediately, pc_init=1, done=0, counters 0, with no clock edge needed.
- start pulse, then 5 plain instructions → pc_init high for the IDLE and INIT cycles, then 5 cycles with branch_en=0. On halt: branch_en=1/val=0, done=1 next cycle, instr_count=6, cycle_count=6.
- is_branch=1 with offset=8'hFC: cond_flag=1 → branch_en=1, branch_val=8'hFC, instr_count+1. cond_flag=0 → branch_en=0.
- mem_busy high for 3 cycles → 3 STALL/RUN cycles with branch_en=1, val=0, and instr_count unchanged. Then one retire; cycle_count+4 total.
- MAX_CYCLES=20 with no halt → done=1 and timeout=1 after 20 run cycles, cycle_count=20, PC held.
- In DONE, start=1 → done drops, INIT pulses pc_init for one cycle, counters read 0 at the first RUN cycle. start asserted during RUN has no effect.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Run-control FSM for the program counter: drives PC init/branch controls, owns the
// start/done handshake with the harness, and counts run cycles and retired instructions.
module fetch_sequencer #(
  parameter int unsigned OFF_W      = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             is_halt,
  input  logic             cond_flag,
  input  logic [OFF_W-1:0] offset,
  input  logic             mem_busy,
  input  logic             pc_halt,
  output logic             pc_init,
  output logic             branch_en,
  output logic [OFF_W-1:0] branch_val,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STALL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic             tick_c;
  logic             retire_c;

  // State register plus the registered status/counter outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
      ins_q     <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

  // Next state, PC controls and counter updates
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    cyc_d      = cyc_q;
    ins_d      = ins_q;
    pc_init    = 1'b0;
    branch_en  = 1'b0;
    branch_val = '0;
    tick_c     = 1'b0;
    retire_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pc_init = 1'b1;
        if (start) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cyc_d     = '0;
          ins_d     = '0;
          state_d   = S_INIT;
        end
      end
      S_INIT: begin
        pc_init = 1'b1;
        state_d = S_RUN;
      end
      S_RUN, S_STALL: begin
        tick_c    = 1'b1;
        branch_en = 1'b1;
        if (cyc_q == WDOG_LAST) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (is_halt) begin
          retire_c = 1'b1;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (pc_halt) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (mem_busy) begin
          state_d = S_STALL;
        end else begin
          // Stall exits re-execute the held instruction through the same path
          retire_c = 1'b1;
          state_d  = S_RUN;
          if (is_jump || (is_branch && cond_flag)) begin
            branch_val = offset;
          end else begin
            branch_en = 1'b0;
          end
        end
      end
      S_DONE: begin
        branch_en = 1'b1;
        if (start) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          cyc_d     = '0;
          ins_d     = '0;
          state_d   = S_INIT;
        end
      end
      default: begin
        pc_init = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (tick_c && (cyc_q != CNT_SAT)) begin
      cyc_d = cyc_q + CNT_W'(1);
    end
    if (retire_c && (ins_q != CNT_SAT)) begin
      ins_d = ins_q + CNT_W'(1);
    end
  end

  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs change on the falling edge, outputs checked 1ns later.
module tb_fetch_sequencer;

  localparam int unsigned OFF_W = 8;
  localparam int unsigned CNT_W = 16;

  logic             CLK;
  logic             RST_N;
  logic             start, is_branch, is_jump, is_halt, cond_flag, mem_busy, pc_halt;
  logic [OFF_W-1:0] offset;
  logic             pc_init, branch_en, done, timeout;
  logic [OFF_W-1:0] branch_val;
  logic [CNT_W-1:0] cycle_count, instr_count;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.OFF_W(OFF_W), .CNT_W(CNT_W), .MAX_CYCLES(20)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .is_branch(is_branch), .is_jump(is_jump),
    .is_halt(is_halt), .cond_flag(cond_flag), .offset(offset), .mem_busy(mem_busy),
    .pc_halt(pc_halt), .pc_init(pc_init), .branch_en(branch_en), .branch_val(branch_val),
    .done(done), .timeout(timeout), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clr_in();
    start = 0; is_branch = 0; is_jump = 0; is_halt = 0; cond_flag = 0;
    mem_busy = 0; pc_halt = 0; offset = '0;
  endtask

  // Advance through one rising edge to the next mid-cycle point
  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // From IDLE/DONE at mid-cycle: pulse start, land on the first RUN cycle
  task automatic start_run();
    clr_in();
    start = 1;
    cyc();
    start = 0;
    cyc();
  endtask

  task automatic test_reset();
    clr_in();
    RST_N = 0;
    #12;
    checks++; if (pc_init !== 1'b1) begin failures++; $display("FAIL reset_pc_init got=%b exp=1", pc_init); end
    checks++; if (branch_en !== 1'b0 || branch_val !== 8'h00) begin failures++; $display("FAIL reset_branch got=%b/%h exp=0/00", branch_en, branch_val); end
    checks++; if (done !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b/%b exp=0/0", done, timeout); end
    checks++; if (cycle_count !== 16'd0 || instr_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", cycle_count, instr_count); end
    @(negedge CLK);
    RST_N = 1;
    #1;
  endtask

  task automatic test_plain_halt();
    @(negedge CLK);
    start = 1;
    #1;
    checks++; if (pc_init !== 1'b1) begin failures++; $display("FAIL idle_pc_init got=%b exp=1", pc_init); end
    cyc();
    start = 0;
    #1;
    checks++; if (pc_init !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL init_pc_init got=%b done=%b exp=1/0", pc_init, done); end
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (pc_init !== 1'b0 || branch_en !== 1'b0) begin failures++; $display("FAIL plain_%0d got pc_init=%b en=%b exp=0/0", i, pc_init, branch_en); end
      checks++; if (instr_count !== 16'(i) || cycle_count !== 16'(i)) begin failures++; $display("FAIL plain_cnt_%0d got=%0d/%0d exp=%0d/%0d", i, cycle_count, instr_count, i, i); end
      cyc();
    end
    is_halt = 1;
    #1;
    checks++; if (branch_en !== 1'b1 || branch_val !== 8'h00) begin failures++; $display("FAIL halt_freeze got=%b/%h exp=1/00", branch_en, branch_val); end
    cyc();
    is_halt = 0;
    #1;
    checks++; if (done !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL halt_done got=%b/%b exp=1/0", done, timeout); end
    checks++; if (instr_count !== 16'd6 || cycle_count !== 16'd6) begin failures++; $display("FAIL halt_counts got cyc=%0d ins=%0d exp=6/6", cycle_count, instr_count); end
    checks++; if (pc_init !== 1'b0 || branch_en !== 1'b1 || branch_val !== 8'h00) begin failures++; $display("FAIL done_hold got=%b/%b/%h exp=0/1/00", pc_init, branch_en, branch_val); end
  endtask

  task automatic test_branch();
    start_run();
    is_branch = 1; cond_flag = 1; offset = 8'hFC;
    #1;
    checks++; if (branch_en !== 1'b1 || branch_val !== 8'hFC) begin failures++; $display("FAIL br_taken got=%b/%h exp=1/fc", branch_en, branch_val); end
    cyc();
    cond_flag = 0;
    #1;
    checks++; if (branch_en !== 1'b0 || instr_count !== 16'd1) begin failures++; $display("FAIL br_not_taken got en=%b ins=%0d exp=0/1", branch_en, instr_count); end
    cyc();
    is_branch = 0; is_jump = 1; offset = 8'h05;
    #1;
    checks++; if (branch_en !== 1'b1 || branch_val !== 8'h05) begin failures++; $display("FAIL jump got=%b/%h exp=1/05", branch_en, branch_val); end
    cyc();
    is_halt = 1; is_branch = 1; cond_flag = 1;
    #1;
    checks++; if (branch_en !== 1'b1 || branch_val !== 8'h00) begin failures++; $display("FAIL halt_prio got=%b/%h exp=1/00", branch_en, branch_val); end
    cyc();
    clr_in();
    #1;
    checks++; if (done !== 1'b1 || instr_count !== 16'd4 || cycle_count !== 16'd4) begin failures++; $display("FAIL br_end got done=%b cyc=%0d ins=%0d exp=1/4/4", done, cycle_count, instr_count); end
  endtask

  task automatic test_stall();
    start_run();
    cyc();
    mem_busy = 1; is_jump = 1; offset = 8'h03;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (branch_en !== 1'b1 || branch_val !== 8'h00 || instr_count !== 16'd1) begin failures++; $display("FAIL stall_%0d got en=%b val=%h ins=%0d exp=1/00/1", i, branch_en, branch_val, instr_count); end
      cyc();
    end
    mem_busy = 0;
    #1;
    checks++; if (branch_en !== 1'b1 || branch_val !== 8'h03) begin failures++; $display("FAIL stall_exit got=%b/%h exp=1/03", branch_en, branch_val); end
    cyc();
    is_jump = 0;
    #1;
    checks++; if (instr_count !== 16'd2 || cycle_count !== 16'd5) begin failures++; $display("FAIL stall_counts got cyc=%0d ins=%0d exp=5/2", cycle_count, instr_count); end
    is_halt = 1;
    cyc();
    is_halt = 0;
  endtask

  task automatic test_pc_halt();
    start_run();
    pc_halt = 1;
    #1;
    checks++; if (branch_en !== 1'b1 || branch_val !== 8'h00) begin failures++; $display("FAIL pc_halt_freeze got=%b/%h exp=1/00", branch_en, branch_val); end
    cyc();
    pc_halt = 0;
    #1;
    checks++; if (done !== 1'b1 || instr_count !== 16'd0 || cycle_count !== 16'd1) begin failures++; $display("FAIL pc_halt_done got done=%b cyc=%0d ins=%0d exp=1/1/0", done, cycle_count, instr_count); end
  endtask

  task automatic test_watchdog();
    start_run();
    for (int i = 0; i < 19; i++) cyc();
    #1;
    checks++; if (branch_en !== 1'b1 || branch_val !== 8'h00 || cycle_count !== 16'd19) begin failures++; $display("FAIL wdog_freeze got en=%b val=%h cyc=%0d exp=1/00/19", branch_en, branch_val, cycle_count); end
    cyc();
    #1;
    checks++; if (done !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL wdog_flags got=%b/%b exp=1/1", done, timeout); end
    checks++; if (cycle_count !== 16'd20 || instr_count !== 16'd19) begin failures++; $display("FAIL wdog_counts got cyc=%0d ins=%0d exp=20/19", cycle_count, instr_count); end
    cyc();
    #1;
    checks++; if (cycle_count !== 16'd20 || branch_en !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL done_frozen got cyc=%0d en=%b done=%b exp=20/1/1", cycle_count, branch_en, done); end
  endtask

  task automatic test_restart();
    start = 1;
    #1;
    checks++; if (pc_init !== 1'b0) begin failures++; $display("FAIL done_start_pc_init got=%b exp=0", pc_init); end
    cyc();
    #1;
    checks++; if (done !== 1'b0 || timeout !== 1'b0 || pc_init !== 1'b1) begin failures++; $display("FAIL restart_init got done=%b to=%b pc_init=%b exp=0/0/1", done, timeout, pc_init); end
    cyc();
    #1;
    checks++; if (pc_init !== 1'b0 || cycle_count !== 16'd0 || instr_count !== 16'd0) begin failures++; $display("FAIL restart_run got pc_init=%b cyc=%0d ins=%0d exp=0/0/0", pc_init, cycle_count, instr_count); end
    cyc();
    #1;
    checks++; if (pc_init !== 1'b0 || cycle_count !== 16'd1 || done !== 1'b0) begin failures++; $display("FAIL start_in_run got pc_init=%b cyc=%0d done=%b exp=0/1/0", pc_init, cycle_count, done); end
    start = 0;
  endtask

  task automatic test_async_reset();
    cyc();
    #2;
    RST_N = 0;
    #1;
    checks++; if (pc_init !== 1'b1 || branch_en !== 1'b0 || cycle_count !== 16'd0 || instr_count !== 16'd0) begin failures++; $display("FAIL async_rst_run got pc_init=%b en=%b cyc=%0d ins=%0d exp=1/0/0/0", pc_init, branch_en, cycle_count, instr_count); end
    @(negedge CLK);
    RST_N = 1;
    start_run();
    is_halt = 1;
    cyc();
    is_halt = 0;
    #2;
    RST_N = 0;
    #1;
    checks++; if (done !== 1'b0 || pc_init !== 1'b1 || instr_count !== 16'd0) begin failures++; $display("FAIL async_rst_done got done=%b pc_init=%b ins=%0d exp=0/1/0", done, pc_init, instr_count); end
    @(negedge CLK);
    RST_N = 1;
  endtask

  initial begin
    test_reset();
    test_plain_halt();
    test_branch();
    test_stall();
    test_pc_halt();
    test_watchdog();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
